shift_add_multiplier: RTL and testbench

//  Iterative radix-2 shift-and-add multiplier. It is the inverse companion of the

---
 rtl/shift_add_multiplier.sv | 94 +++++++++
 tb/tb_shift_add_multiplier.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Iterative radix-2 shift-and-add multiplier, one multiplier bit per clock.
// Signed mode multiplies magnitudes and negates the product at the end.
module shift_add_multiplier #(
  parameter int DATA_WIDTH = 32,
  parameter int SIGNED     = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     din_a,
  input  logic [DATA_WIDTH-1:0]     din_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   dout
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    mcand;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic            sa;
  logic            sb;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W:0]      sum;
  logic [2*W-1:0]  nxt;

  // Low half of acc holds the unconsumed multiplier bits; product bits
  // shift in from the top as they are consumed.
  always_comb begin
    sa    = (SIGNED != 0) && din_a[W-1];
    sb    = (SIGNED != 0) && din_b[W-1];
    mag_a = sa ? -din_a : din_a;
    mag_b = sb ? -din_b : din_b;
    sum   = {1'b0, acc[2*W-1:W]};
    if (acc[0]) begin
      sum = sum + {1'b0, mcand};
    end
    nxt   = {sum, acc[W-1:1]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      dout  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= mag_a;
            acc   <= {{W{1'b0}}, mag_b};
            cnt   <= '0;
            neg   <= sa ^ sb;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            dout  <= neg ? -nxt : nxt;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: directed vectors, reset, back-pressure,
// and randomized streaming at 8/32 bits, signed and unsigned.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        iv   [4];
  logic        irdy [4];
  logic        ov   [4];
  logic        ordy [4];
  logic [31:0] a    [4];
  logic [31:0] b    [4];
  logic [63:0] dq   [4];

  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // g: 0 = 32u, 1 = 32s, 2 = 8u, 3 = 8s
  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = (g < 2) ? 32 : 8;
    localparam int S = g % 2;
    logic [2*W-1:0] d;
    shift_add_multiplier #(
      .DATA_WIDTH(W),
      .SIGNED    (S)
    ) u_dut (
      .clock    (clk),
      .reset_n  (rst_n),
      .in_valid (iv[g]),
      .in_ready (irdy[g]),
      .din_a    (a[g][W-1:0]),
      .din_b    (b[g][W-1:0]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .dout     (d)
    );
    assign dq[g] = 64'(d);
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] x, input int w);
    longint v;
    v = longint'({32'b0, x});
    if (x[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: plain integer multiply, truncated to 2w bits.
  function automatic logic [63:0] model(input int w, input bit s,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] m2;
    logic [63:0] p;
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (2 * w)) - 1);
    if (s) p = 64'(sx(x, w) * sx(y, w));
    else   p = 64'(x) * 64'(y);
    return p & m2;
  endfunction

  task automatic do_op(input int g, input logic [31:0] x,
                       input logic [31:0] y,
                       output logic [63:0] r, output int lat);
    @(negedge clk);
    a[g]  = x;
    b[g]  = y;
    iv[g] = 1'b1;
    @(negedge clk);
    iv[g] = 1'b0;
    lat   = 0;
    while (!ov[g] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    r       = dq[g];
    ordy[g] = 1'b1;
    @(negedge clk);
    ordy[g] = 1'b0;
  endtask

  function automatic logic [31:0] pick(input logic [31:0] mask,
                                       input int w);
    int r;
    r = $urandom % 8;
    if (r == 0) return 32'h0;
    if (r == 1) return mask;
    if (r == 2) return 32'h1 << (w - 1);
    return $urandom & mask;
  endfunction

  task automatic stream(input int g, input int n);
    int          w;
    bit          s;
    logic [31:0] mask;
    logic [63:0] q[$];
    logic [63:0] e;
    int          sent;
    int          got;
    int          cyc;
    w    = (g < 2) ? 32 : 8;
    s    = (g % 2) == 1;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'hFF;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < n && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      ordy[g] = ($urandom % 3) != 0;
      if (ov[g] && ordy[g]) begin
        if (q.size() == 0) begin
          chk($sformatf("stream%0d_extra", g), dq[g], 64'hx);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream%0d_prod", g), dq[g], e);
        end
        got++;
      end
      if (sent < n) begin
        iv[g] = ($urandom % 2) == 1;
        a[g]  = pick(mask, w);
        b[g]  = pick(mask, w);
        if (iv[g] && irdy[g]) begin
          q.push_back(model(w, s, a[g], b[g]));
          sent++;
        end
      end else begin
        iv[g] = 1'b0;
      end
    end
    @(negedge clk);
    ordy[g] = 1'b0;
    iv[g]   = 1'b0;
    chk($sformatf("stream%0d_count", g), 64'(got), 64'(n));
    chk($sformatf("stream%0d_left", g), 64'(q.size()), 64'd0);
  endtask

  typedef struct {
    string       nm;
    int          g;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;
  } vec_t;

  vec_t        vt [10];
  logic [63:0] r;
  int          lat;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b0;
      a[i]    = '0;
      b[i]    = '0;
    end

    vt[0] = '{"u_ff_ff",   0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vt[1] = '{"u_zero",    0, 32'h0,         32'h1234_5678, 64'h0};
    vt[2] = '{"u_one",     0, 32'h1,         32'h1234_5678, 64'h1234_5678};
    vt[3] = '{"s_m3x7",    1, 32'hFFFF_FFFD, 32'h7,         64'hFFFF_FFFF_FFFF_FFEB};
    vt[4] = '{"s_min_min", 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vt[5] = '{"s_min_one", 1, 32'h8000_0000, 32'h1,         64'hFFFF_FFFF_8000_0000};
    vt[6] = '{"s_m1_m1",   1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
    vt[7] = '{"s_max_min", 1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vt[8] = '{"s_zero",    1, 32'h0,         32'h1234_5678, 64'h0};
    vt[9] = '{"u_msb_two", 0, 32'h8000_0000, 32'h2,         64'h1_0000_0000};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_rdy%0d", i), 64'(irdy[i]), 64'd1);
      chk($sformatf("rst_ov%0d", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst_dout%0d", i), dq[i], 64'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].g, vt[i].x, vt[i].y, r, lat);
      chk(vt[i].nm, r, vt[i].e);
      chk({vt[i].nm, "_lat"}, 64'(lat), 64'd32);
      chk({vt[i].nm, "_idle"}, 64'(irdy[vt[i].g]), 64'd1);
    end

    // reset in the middle of an operation
    @(negedge clk);
    a[0]  = 32'd5;
    b[0]  = 32'd7;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ov", 64'(ov[0]), 64'd0);
    chk("midrst_rdy", 64'(irdy[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 32'd3, 32'd4, r, lat);
    chk("after_rst", r, 64'd12);
    chk("after_rst_lat", 64'(lat), 64'd32);

    // back-pressure with ignored input pulses
    @(negedge clk);
    a[0]  = 32'h1234;
    b[0]  = 32'h10;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    lat   = 0;
    while (!ov[0] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 64'(lat), 64'd32);
    for (int i = 0; i < 20; i++) begin
      chk("bp_dout", dq[0], 64'h12340);
      chk("bp_rdy", 64'(irdy[0]), 64'd0);
      chk("bp_ov", 64'(ov[0]), 64'd1);
      @(negedge clk);
      iv[0] = 1'(i % 2);
      a[0]  = $urandom;
      b[0]  = $urandom;
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp_rel_ov", 64'(ov[0]), 64'd0);
    chk("bp_rel_rdy", 64'(irdy[0]), 64'd1);
    repeat (40) @(negedge clk);
    chk("bp_no_ghost", 64'(ov[0]), 64'd0);

    stream(2, 1000);
    stream(3, 1000);
    stream(0, 200);
    stream(1, 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
